// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM/WB connection of the memory stage: inputs from execute,
// stall back to upstream, and the MEM/WB register outputs.
interface mem_stage_if;
  logic        Mwk;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [31:0] AluOutput;
  logic [31:0] StoreData;
  logic [31:0] LinkAddr;
  logic [4:0]  Rd;
  logic        RegWr;
  logic        Stall;
  logic [31:0] WbData;
  logic [4:0]  WbRd;
  logic        WbRegWr;
  logic        WbValid;

  modport master (
    output Mwk, op, funct3, AluOutput, StoreData, LinkAddr, Rd, RegWr,
    input  Stall, WbData, WbRd, WbRegWr, WbValid
  );

  modport slave (
    input  Mwk, op, funct3, AluOutput, StoreData, LinkAddr, Rd, RegWr,
    output Stall, WbData, WbRd, WbRegWr, WbValid
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores to an internal
// RAM, splitting word-crossing accesses over two cycles, feeding MEM/WB.
module mem_stage #(
  parameter int AW = 8
) (
  input logic         CLK,
  input logic         Reset,
  mem_stage_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BUBBLE = 7'b1111111;

  logic [31:0]   r_ram [2**AW];
  logic [0:0]    r_state;
  logic [31:0]   r_partial;
  logic [31:0]   r_wbData;
  logic [4:0]    r_wbRd;
  logic          r_wbRegWr;
  logic          r_wbValid;

  logic [AW-1:0] w_wordIdx;
  logic [AW-1:0] w_wordNext;
  logic [1:0]    w_byteOff;
  logic [4:0]    w_shift;
  logic          w_isLoad;
  logic          w_isStore;
  logic          w_isByte;
  logic          w_isHalf;
  logic          w_cross;
  logic [3:0]    w_sizeMask;
  logic [7:0]    w_mask8;
  logic [63:0]   w_stData64;
  logic [31:0]   w_loWord;
  logic [63:0]   w_raw64;
  logic [31:0]   w_raw;
  logic [31:0]   w_loadVal;
  logic [31:0]   w_wbData;
  logic [4:0]    w_wbRd;
  logic          w_wbRegWr;
  logic          w_wbValid;
  logic          w_unused;

  assign w_wordIdx  = bus.AluOutput[AW+1:2];
  assign w_wordNext = w_wordIdx + {{(AW-1){1'b0}}, 1'b1};
  assign w_byteOff  = bus.AluOutput[1:0];
  assign w_shift    = {w_byteOff, 3'b000};

  assign w_isLoad  = (bus.op == OP_LOAD);
  assign w_isStore = (bus.op == OP_STORE);
  assign w_isByte  = (bus.funct3 == 3'b000) || (w_isLoad && bus.funct3 == 3'b100);
  assign w_isHalf  = (bus.funct3 == 3'b001) || (w_isLoad && bus.funct3 == 3'b101);

  // Anything neither byte nor half is treated as a full word.
  assign w_sizeMask = w_isByte ? 4'b0001 : (w_isHalf ? 4'b0011 : 4'b1111);
  assign w_cross    = (w_isLoad || w_isStore) &&
                      ((w_isHalf && w_byteOff == 2'd3) ||
                       (!w_isByte && !w_isHalf && w_byteOff != 2'd0));

  // Low/high words of the 64-bit window are written in IDLE/SPLIT respectively.
  assign w_mask8    = {4'b0000, w_sizeMask} << w_byteOff;
  assign w_stData64 = {32'h0, bus.StoreData} << w_shift;

  assign w_loWord  = (r_state == SPLIT) ? r_partial : r_ram[w_wordIdx];
  assign w_raw64   = {r_ram[w_wordNext], w_loWord} >> w_shift;
  assign w_raw     = w_raw64[31:0];
  assign w_loadVal = w_isByte ? (bus.funct3[2] ? {24'h0, w_raw[7:0]}
                                               : {{24{w_raw[7]}}, w_raw[7:0]})
                   : w_isHalf ? (bus.funct3[2] ? {16'h0, w_raw[15:0]}
                                               : {{16{w_raw[15]}}, w_raw[15:0]})
                   : w_raw;

  assign w_unused = ^{bus.AluOutput[31:AW+2], w_raw64[63:32]};

  always_comb begin
    w_wbData  = bus.AluOutput;
    w_wbRd    = bus.Rd;
    w_wbRegWr = bus.RegWr && (bus.Rd != 5'd0);
    w_wbValid = 1'b1;
    if (bus.op == OP_BUBBLE) begin
      w_wbData  = 32'h0;
      w_wbRd    = 5'd0;
      w_wbRegWr = 1'b0;
      w_wbValid = 1'b0;
    end else if (w_isLoad) begin
      w_wbData = w_loadVal;
    end else if (bus.op == OP_JAL || bus.op == OP_JALR) begin
      w_wbData = bus.LinkAddr;
    end else if (w_isStore || bus.op == OP_BRANCH) begin
      w_wbRegWr = 1'b0;
    end
  end

  // Reset is folded in so an aborted split drops the stall without a clock.
  assign bus.Stall = !Reset && (r_state == IDLE) && w_cross;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_partial <= 32'h0;
      r_wbData  <= 32'h0;
      r_wbRd    <= 5'd0;
      r_wbRegWr <= 1'b0;
      r_wbValid <= 1'b0;
    end else if (bus.Mwk) begin
      if (r_state == IDLE && w_cross) begin
        r_state   <= SPLIT;
        r_partial <= r_ram[w_wordIdx];
        r_wbData  <= 32'h0;
        r_wbRd    <= 5'd0;
        r_wbRegWr <= 1'b0;
        r_wbValid <= 1'b0;
      end else begin
        r_state   <= IDLE;
        r_wbData  <= w_wbData;
        r_wbRd    <= w_wbRd;
        r_wbRegWr <= w_wbRegWr;
        r_wbValid <= w_wbValid;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset && bus.Mwk && w_isStore) begin
      for (int k = 0; k < 4; k++) begin
        if (r_state == IDLE && w_mask8[k])
          r_ram[w_wordIdx][8*k +: 8] <= w_stData64[8*k +: 8];
        if (r_state == SPLIT && w_mask8[k+4])
          r_ram[w_wordNext][8*k +: 8] <= w_stData64[32 + 8*k +: 8];
      end
    end
  end

  assign bus.WbData  = r_wbData;
  assign bus.WbRd    = r_wbRd;
  assign bus.WbRegWr = r_wbRegWr;
  assign bus.WbValid = r_wbValid;

endmodule
